sram_uart_dumper: RTL and testbench
===================================

Name: sram_uart_dumper

Overview:
Read-back path for the uart2sram design: reads a contiguous range of 32-bit words from SRAM and serialises each word as four 8N1 UART bytes on txd, MSB byte first. It is the reader counterpart of the UART-receive/SRAM-write path and lets the host verify a downloaded program image. It owns its own baud timing and serialiser, so it does not share the receive-side baud generator.

Parameters:
BAUD_DIV, 5208, clk cycles per UART bit (50 MHz / 9600); legal range >= 2
ADDR_W, 20, SRAM word-address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches base_addr and word_count when idle
base_addr  in  ADDR_W  first word address
word_count  in  ADDR_W  number of words to dump; 0 = none
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of dump
sram_req  out  1  read request; held until sram_ack
sram_addr  out  ADDR_W  word address; stable while sram_req
sram_ack  in  1  read complete; sram_rdata valid in the same cycle
sram_rdata  in  32  read data
txd  out  1  UART line, idle high

Behaviour:
- Reset (async, rst_n=0): txd=1, busy=0, done=0, sram_req=0, sram_addr=0, FSM=IDLE, serialiser idle, all counters cleared. Reset mid-frame truncates the frame; txd goes high immediately.
- FSM states: IDLE, REQ, SEND, WAIT_TX, NEXT, FIN.
- IDLE: start=1 with word_count!=0 latches addr=base_addr and remaining=word_count, then -> REQ. start=1 with word_count=0 -> FIN. No bus activity and no txd activity in that case.
- REQ: sram_req=1, sram_addr=addr. On sram_ack, capture sram_rdata into word_reg, drop sram_req in the following cycle, set byte_idx=0, then -> SEND.
- SEND: pulse tx_start for one cycle with the byte word_reg[31-8*byte_idx -: 8], then -> WAIT_TX.
- WAIT_TX: wait for tx_done. If byte_idx<3, increment byte_idx and -> SEND. Otherwise -> NEXT.
- NEXT: decrement remaining and increment addr. addr wraps modulo 2^ADDR_W (no error). If remaining is now 0 -> FIN, else -> REQ.
- FIN: done=1 for exactly one cycle, busy=0 from the next cycle, -> IDLE.
- busy: 1 in every state except IDLE. It also stays 1 for the FIN cycle.
- start while busy: ignored. No relatch and no restart.
- Timing: start accepted at cycle 0 -> sram_req=1 at cycle 1. Start bit of byte 0 begins 2 cycles after the sram_ack cycle.
- Serialiser frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
- tx_done pulses in the last cycle of the stop bit. Gap between consecutive frames: txd stays high for exactly 2 idle clocks (WAIT_TX->SEND, SEND->serialiser load). That gap is also the only high-time between the stop bit of one frame and the start bit of the next.
- done fires 3 cycles after the final tx_done (WAIT_TX->NEXT->FIN).
- sram_ack while sram_req=0: ignored.
- A stalled SRAM (no ack) holds REQ indefinitely. There is no timeout.

Decomposition:
- Shared package holds:
  - UART constants: frame length 10, START_BIT=0, STOP_BIT=1, default BAUD_DIV=5208.
  - FSM state encoding (3-bit enum).
- One sub-module, uart_tx_byte (clk, rst_n, tx_start, tx_data[7:0], tx_busy, tx_done, txd), parameterised on BAUD_DIV.
  - It contains the bit-period counter (width clog2(BAUD_DIV)), the 4-bit bit counter and the shift register.
  - tx_start while tx_busy is ignored.
- The top level holds the FSM, address and remaining counters, and word_reg.

Test Plan:
1. Single word: BAUD_DIV=4, base_addr=0x00010, word_count=1, SRAM returns 0xDEADBEEF after 3-cycle ack latency -> one sram_req at addr 0x00010; txd bytes DE, AD, BE, EF, each 40 cycles LSB-first with 2-cycle high gaps; done pulses once; busy then falls.
2. Multi-word: word_count=3 at base 0x00100, memory = word address -> addresses 0x100, 0x101, 0x102 requested in order; 12 bytes decoded by the bench UART monitor match; exactly one done.
3. word_count=0 -> done pulses at cycle 1, sram_req never asserts, txd constant 1.
4. Wrap: ADDR_W=4, base_addr=0xF, word_count=2 -> requests addr 0xF then 0x0.
5. Start while busy: second start with different base mid-dump -> ignored; original sequence completes unchanged.
6. Reset mid-frame: rst_n=0 during bit 4 of byte 1 -> txd=1, sram_req=0, busy=0 asynchronously; a new start afterwards produces a clean full dump.

Source files
------------

// File: rtl/sram_uart_dumper_pkg.sv
// Shared constants and FSM encoding for the SRAM-to-UART read-back path.
// Imported by the serialiser and the dumper top level.
package sram_uart_dumper_pkg;

  localparam int   FRAME_LEN    = 10;
  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;
  localparam int   BAUD_DIV_DEF = 5208;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_TX = 3'd3,
    S_NEXT    = 3'd4,
    S_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/sram_uart_dumper_uart_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// tx_done is asserted in the last clock of the stop bit.
module uart_tx_byte
  import sram_uart_dumper_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_LEN - 1);
  localparam logic [3:0] BIT_STOP = 4'(FRAME_LEN - 2);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = busy_q && (baud_q == BAUD_LAST);
  assign tx_done = bit_end && (bit_q == BIT_LAST);
  assign tx_busy = busy_q;
  assign txd     = txd_q;

  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    txd_d  = txd_q;
    if (!busy_q) begin
      if (tx_start) begin
        busy_d = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        sh_d   = tx_data;
        txd_d  = START_BIT;
      end
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      if (bit_q == BIT_LAST) begin
        busy_d = 1'b0;
        bit_d  = '0;
        txd_d  = STOP_BIT;
      end else if (bit_q == BIT_STOP) begin
        txd_d = STOP_BIT;
      end else begin
        txd_d = sh_q[0];
        sh_d  = {1'b0, sh_q[7:1]};
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      busy_q <= 1'b0;
      txd_q  <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
      txd_q  <= txd_d;
    end
  end

endmodule

// File: rtl/sram_uart_dumper.sv
// Reads a word range from SRAM and streams each word as four UART
// bytes, MSB byte first.
module sram_uart_dumper
  import sram_uart_dumper_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ack,
  input  logic [31:0]       sram_rdata,
  output logic              txd
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic              txdone_q;

  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign sram_req  = (state_q == S_REQ);
  assign sram_addr = addr_q;

  always_comb begin
    unique case (byte_q)
      2'd0: tx_data = word_q[31:24];
      2'd1: tx_data = word_q[23:16];
      2'd2: tx_data = word_q[15:8];
      2'd3: tx_data = word_q[7:0];
    endcase
  end

  // tx_done is registered once, which sets the 2-clock inter-frame gap
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    word_d   = word_q;
    byte_d   = byte_q;
    tx_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        if (sram_ack) begin
          word_d  = sram_rdata;
          byte_d  = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (txdone_q) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_SEND;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        rem_d   = rem_q - ONE;
        addr_d  = addr_q + ONE;
        state_d = (rem_q == ONE) ? S_FIN : S_REQ;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      word_q   <= '0;
      byte_q   <= '0;
      txdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      txdone_q <= tx_done;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (txd)
  );

endmodule

// File: tb/tb_sram_uart_dumper.sv
// Scoreboard bench: stimulus pushes expected addresses/bytes/done,
// monitors on the SRAM port, txd line and done pop and compare.
module tb_sram_uart_dumper;

  localparam int B  = 4;
  localparam int AW = 20;
  localparam int FR = 10 * B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic          busy, done, sram_req, txd;
  logic [AW-1:0] sram_addr;
  logic          sram_ack = 1'b0;
  logic [31:0]   sram_rdata = '0;

  sram_uart_dumper #(.BAUD_DIV(B), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .sram_req  (sram_req),
    .sram_addr (sram_addr),
    .sram_ack  (sram_ack),
    .sram_rdata(sram_rdata),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // memory contents and reference model
  int          mem_mode = 0;
  logic [31:0] mem_key = '0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (mem_mode)
      0: return 32'hDEADBEEF;
      1: return 32'(a);
      default: return mem_key ^ (32'(a) * 32'h9E3779B9);
    endcase
  endfunction

  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_byte[$];
  bit            exp_done[$];
  int            start_cyc = 0;

  // SRAM responder + address monitor
  int lat_cfg = 0;
  int wait_cnt = 0;
  int req_cycles = 0;
  int ack_cyc = -100;
  bit spur_en = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sram_ack = 1'b0;
      wait_cnt = 0;
    end else if (sram_ack) begin
      sram_ack = 1'b0;
    end else if (sram_req) begin
      req_cycles++;
      if (wait_cnt == 0) begin
        sram_ack   = 1'b1;
        sram_rdata = mem_word(sram_addr);
        ack_cyc    = cyc;
        chk("req_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0)
          chk("sram_addr", 64'(sram_addr), 64'(exp_addr.pop_front()));
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
      if (spur_en && $urandom_range(7, 0) == 0) begin
        sram_ack   = 1'b1;
        sram_rdata = $urandom;
      end
    end
  end

  // UART line monitor
  bit         rx_act = 0;
  int         rx_t0 = 0;
  int         rx_frames = 0;
  int         prev_end = -1000;
  int         byte_in_word = 0;
  int         low_cycles = 0;
  logic [7:0] rx_exp, rx_got;
  bit         rx_bad;
  int         rk, rj;
  logic       eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 0;
      byte_in_word = 0;
    end else begin
      if (!txd) low_cycles++;
      if (!rx_act && !txd) begin
        rx_act = 1;
        rx_t0  = cyc;
        rx_bad = 0;
        rx_got = '0;
        rx_frames++;
        chk("frame_expected", 64'(exp_byte.size() != 0), 64'd1);
        rx_exp = '0;
        if (exp_byte.size() != 0) rx_exp = exp_byte.pop_front();
        if (byte_in_word == 0)
          chk("first_bit_latency", 64'(cyc - ack_cyc), 64'd2);
        else
          chk("frame_gap", 64'(cyc - prev_end - 1), 64'd2);
      end
      if (rx_act) begin
        rk = cyc - rx_t0;
        rj = rk / B;
        if (rj == 0) eb = 1'b0;
        else if (rj == 9) eb = 1'b1;
        else eb = rx_exp[rj-1];
        if (txd !== eb) rx_bad = 1;
        if (rj >= 1 && rj <= 8 && (rk % B) == B / 2) rx_got[rj-1] = txd;
        if (rk == FR - 1) begin
          chk("frame_byte", {55'd0, rx_bad, rx_got}, {56'd0, rx_exp});
          rx_act = 0;
          prev_end = cyc;
          byte_in_word = (byte_in_word + 1) % 4;
        end
      end
    end
  end

  // done monitor
  bit after_done = 0;
  bit dz;

  always @(negedge clk) begin
    if (!rst_n) begin
      after_done = 0;
    end else begin
      if (after_done) begin
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        after_done = 0;
      end
      if (done) begin
        after_done = 1;
        chk("busy_in_fin", 64'(busy), 64'd1);
        chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) begin
          dz = exp_done.pop_front();
          if (dz) chk("done_zero_cycle", 64'(cyc - start_cyc), 64'd1);
          else chk("done_latency", 64'(cyc - prev_end), 64'd3);
          chk("addr_left", 64'(exp_addr.size()), 64'd0);
          chk("bytes_left", 64'(exp_byte.size()), 64'd0);
        end
      end
    end
  end

  // stimulus
  task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    logic [31:0]   w;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    start_cyc  = cyc;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      w = mem_word(a);
      exp_byte.push_back(w[31:24]);
      exp_byte.push_back(w[23:16]);
      exp_byte.push_back(w[15:8]);
      exp_byte.push_back(w[7:0]);
    end
    exp_done.push_back(n == '0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (lat_cfg == 0 && !spur_en)
      chk("req_after_start", 64'(sram_req), 64'(n != '0));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_done.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n < budget) n_pass++;
    else $display("FAIL timeout: waited %0d cycles, limit %0d", n, budget);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  int rc, lc, tgt, guard;
  logic [AW-1:0] rb, rn;

  initial begin
    #12;
    chk("rst_txd", 64'(txd), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(sram_req), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word, 3-cycle ack latency
    mem_mode = 0;
    lat_cfg  = 3;
    issue(20'h00010, 20'd1);
    wait_idle(2000);

    // multi-word, data = address
    mem_mode = 1;
    lat_cfg  = 0;
    issue(20'h00100, 20'd3);
    wait_idle(4000);

    // zero words: no bus or line activity
    rc = req_cycles;
    lc = low_cycles;
    issue(20'h00555, 20'd0);
    wait_idle(100);
    chk("zero_no_req", 64'(req_cycles - rc), 64'd0);
    chk("zero_no_txd", 64'(low_cycles - lc), 64'd0);

    // address wrap
    mem_mode = 2;
    mem_key  = 32'h1234_5678;
    lat_cfg  = 1;
    issue(20'hFFFFF, 20'd2);
    wait_idle(4000);

    // start while busy must be ignored
    issue(20'h00200, 20'd3);
    repeat (150) @(negedge clk);
    pulse_start(20'h00300, 20'd5);
    repeat (40) @(negedge clk);
    pulse_start(20'h00000, 20'd0);
    wait_idle(4000);

    // reset during data bit 4 of byte 1 (0xAD: bit 4 is 0)
    mem_mode = 0;
    lat_cfg  = 1;
    tgt = rx_frames + 2;
    issue(20'h00040, 20'd2);
    guard = 0;
    while (rx_frames < tgt && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    chk("reach_byte1", 64'(rx_frames >= tgt), 64'd1);
    repeat (5 * B) @(posedge clk);
    #2;
    chk("pre_reset_txd", 64'(txd), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 64'(txd), 64'd1);
    chk("async_rst_req", 64'(sram_req), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    exp_addr.delete();
    exp_byte.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_mode = 1;
    issue(20'h00777, 20'd2);
    wait_idle(4000);

    // randomized dumps with random latency and stray acks
    mem_mode = 2;
    lat_cfg  = -1;
    spur_en  = 1;
    for (int r = 0; r < 8; r++) begin
      mem_key = $urandom;
      rb = AW'($urandom);
      if ($urandom_range(3, 0) == 0) rb = 20'hFFFFE;
      rn = AW'($urandom_range(3, 1));
      issue(rb, rn);
      wait_idle(6000);
      repeat ($urandom_range(5, 0)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
